// File: rtl/tx_serializer_10b_pkg.sv
// Shared code-group constants for the 8b/10b transmit path.
// Used by the encoder tables and by tx_serializer_10b.
//   CG_WIDTH          : code-group width (abcdei fghj, bit 9 = 'a')
//   K28_5_RDN/RDP     : K28.5 comma in the RD- and RD+ columns
//   ser_state_e       : serializer FSM encoding (SER_IDLE, SER_SHIFT)
package tx_serializer_10b_pkg;

    localparam int unsigned CG_WIDTH = 10;

    localparam logic [CG_WIDTH-1:0] K28_5_RDN = 10'b0011111010;
    localparam logic [CG_WIDTH-1:0] K28_5_RDP = 10'b1100000101;

    typedef enum logic [0:0] {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry valid/ready holding register in front of the serializer.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   in_data     : incoming code group
//   in_valid    : in_data is valid
//   in_ready    : entry is free, or is being drained at this edge
//   take        : consumer loads hold_data at this edge
//   hold_valid  : entry holds a code group
//   hold_data   : held code group
module ser_hold_buf
    import tx_serializer_10b_pkg::*;
#(
    parameter int unsigned WIDTH = CG_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             take,
    output logic             hold_valid,
    output logic [WIDTH-1:0] hold_data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             accept;

    // Ready depends only on registered state and take, never on in_valid.
    assign in_ready = !valid_q || take;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (accept) begin
            // Covers the load-and-accept case: the old entry leaves via take.
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (take) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign hold_valid = valid_q;
    assign hold_data  = data_q;

endmodule

// File: rtl/tx_serializer_10b.sv
// 10-bit code-group serializer following the 8b/10b encoder.
// Accepts code groups through a one-entry buffer and shifts them out MSB ('a') first,
// one bit per clk. Once started the stream never gaps: on underflow FILL_PATTERN is sent.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   cg_in      : code group, bit 9 = 'a', bit 0 = 'j'
//   cg_valid   : cg_in valid
//   cg_ready   : cg_in is accepted at this edge when cg_valid is high
//   ser_out    : registered serial bit
//   tx_active  : stream has started
//   sym_start  : ser_out carries bit 'a'
//   underflow  : one-cycle pulse while the filler's first bit is on ser_out
//   uf_count   : saturating underflow count (only with SER_UNDERFLOW_CNT_EN defined)
module tx_serializer_10b
    import tx_serializer_10b_pkg::*;
#(
    parameter int unsigned          CG_WIDTH     = tx_serializer_10b_pkg::CG_WIDTH,
    parameter logic [CG_WIDTH-1:0]  FILL_PATTERN = K28_5_RDN
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CG_WIDTH-1:0] cg_in,
    input  logic                cg_valid,
    output logic                cg_ready,
    output logic                ser_out,
    output logic                tx_active,
    output logic                sym_start,
    output logic                underflow
`ifdef SER_UNDERFLOW_CNT_EN
    ,
    output logic [7:0]          uf_count
`endif
);

    localparam logic [3:0] LAST_BIT = 4'(CG_WIDTH - 1);

    ser_state_e          state_q, state_d;
    logic [CG_WIDTH-1:0] shift_q, shift_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic                underflow_q, underflow_d;

    logic                hold_valid;
    logic [CG_WIDTH-1:0] hold_data;
    logic                load_now;

    assign load_now = (state_q == SER_IDLE  && hold_valid) ||
                      (state_q == SER_SHIFT && bit_cnt_q == LAST_BIT);

    ser_hold_buf #(
        .WIDTH (CG_WIDTH)
    ) u_hold_buf (
        .clk        (clk),
        .reset      (reset),
        .in_data    (cg_in),
        .in_valid   (cg_valid),
        .in_ready   (cg_ready),
        .take       (load_now),
        .hold_valid (hold_valid),
        .hold_data  (hold_data)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        underflow_d = 1'b0;
        unique case (state_q)
            SER_IDLE: begin
                if (hold_valid) begin
                    shift_d   = hold_data;
                    bit_cnt_d = '0;
                    state_d   = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    if (hold_valid) begin
                        shift_d = hold_data;
                    end else begin
                        shift_d     = FILL_PATTERN;
                        underflow_d = 1'b1;
                    end
                end else begin
                    shift_d   = {shift_q[CG_WIDTH-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SER_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            underflow_q <= underflow_d;
        end
    end

    // shift_q stays zero in IDLE, so ser_out is 0 there without extra gating.
    assign ser_out   = shift_q[CG_WIDTH-1];
    assign tx_active = (state_q == SER_SHIFT);
    assign sym_start = (state_q == SER_SHIFT) && (bit_cnt_q == 4'd0);
    assign underflow = underflow_q;

`ifdef SER_UNDERFLOW_CNT_EN
    logic [7:0] uf_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uf_count_q <= 8'h00;
        end else if (underflow_q && uf_count_q != 8'hFF) begin
            uf_count_q <= uf_count_q + 8'd1;
        end
    end

    assign uf_count = uf_count_q;
`endif

endmodule
